// File: rtl/brick_game_sequencer_pkg.sv
// Shared constants, column codes and state type for the brick game controller.
package brick_game_sequencer_pkg;

  localparam int unsigned ROW_COUNT  = 6;
  localparam logic [2:0]  MAX_HEIGHT = 3'(ROW_COUNT - 1);

  localparam logic [1:0] COL_LEFT   = 2'd0;
  localparam logic [1:0] COL_CENTRE = 2'd1;
  localparam logic [1:0] COL_RIGHT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FALL,
    ST_LAND,
    ST_OVER
  } game_state_t;

  // Stack grows by one, never beyond the top row.
  function automatic logic [2:0] height_inc(input logic [2:0] h);
    return (h >= MAX_HEIGHT) ? MAX_HEIGHT : h + 3'd1;
  endfunction

  // Stack shrinks by one, never below empty.
  function automatic logic [2:0] height_dec(input logic [2:0] h);
    return (h == 3'd0) ? 3'd0 : h - 3'd1;
  endfunction

endpackage

// File: rtl/brick_game_sequencer_fall_tick_gen.sv
// Programmable-period fall timer: counts while enabled, emits a registered
// one-cycle expiry strobe, and restarts from zero after each expiry.
module fall_tick_gen #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             expire
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;
  logic [CNT_W:0]   limit;

  assign count_inc = {1'b0, count} + (CNT_W + 1)'(1);
  assign limit     = {1'b0, period} - (CNT_W + 1)'(1);

  // The strobe is registered, so it is raised one edge ahead: it is high in
  // the cycle whose count has reached period-1 (or beyond, if the period
  // shortened mid-count).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (enable) begin
      if (expire) begin
        count  <= '0;
        expire <= 1'b0;
      end else begin
        count  <= count_inc[CNT_W-1:0];
        expire <= (count_inc >= limit);
      end
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/brick_game_sequencer.sv
// Top-level controller for the three-column falling-brick game: stack heights,
// fall pulses, column moves from buttons, scoring and idle/play/over sequencing.
module brick_game_sequencer
  import brick_game_sequencer_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned FAST_CYCLES = 2_500_000,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_drop,
  input  logic               plus_gauche,
  input  logic               plus_centre,
  input  logic               plus_droite,
  input  logic               aligne,
  input  logic               perdu,
  input  logic [2:0]         row,
  output logic               pulse,
  output logic [1:0]         col,
  output logic [2:0]         hauteur_gauche,
  output logic [2:0]         hauteur_centre,
  output logic [2:0]         hauteur_droite,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_over
);

  localparam int unsigned MAX_CYCLES = (TICK_CYCLES > FAST_CYCLES) ? TICK_CYCLES : FAST_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  game_state_t      state;
  logic [2:0][2:0]  heights;
  logic [2:0][2:0]  heights_land;
  logic             start_q;
  logic             left_q;
  logic             right_q;
  logic             start_rise;
  logic             left_rise;
  logic             right_rise;
  logic [1:0]       col_moved;
  logic [2:0]       plus_vec;
  logic             landing;
  logic             land_full;
  logic [SCORE_W-1:0] score_inc;
  logic             tick_enable;
  logic             tick_clear;
  logic [CNT_W-1:0] tick_period;

  assign start_rise = start & ~start_q;
  assign left_rise  = btn_left & ~left_q;
  assign right_rise = btn_right & ~right_q;

  assign plus_vec  = {plus_droite, plus_centre, plus_gauche};
  assign landing   = aligne | (|plus_vec);
  assign score_inc = (score == '1) ? score : score + SCORE_W'(1);

  assign tick_enable = (state == ST_FALL);
  assign tick_clear  = start_rise && ((state == ST_IDLE) || (state == ST_OVER));
  assign tick_period = btn_drop ? CNT_W'(FAST_CYCLES) : CNT_W'(TICK_CYCLES);

  fall_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (tick_enable),
    .clear  (tick_clear),
    .period (tick_period),
    .expire (pulse)
  );

  function automatic logic [2:0] height_at(input logic [2:0][2:0] h, input logic [1:0] c);
    case (c)
      COL_LEFT:   return h[0];
      COL_CENTRE: return h[1];
      COL_RIGHT:  return h[2];
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic move_blocked(input logic [2:0][2:0] h, input logic [1:0] c,
                                        input logic [2:0] r);
    return ({1'b0, height_at(h, c)} + {1'b0, r}) > {1'b0, MAX_HEIGHT};
  endfunction

  // Column after a button move: single-direction rises only, clamped at the
  // edges, and refused when the brick would overlap the target stack.
  always_comb begin
    col_moved = col;
    if (left_rise && !right_rise && col != COL_LEFT) begin
      if (!move_blocked(heights, col - 2'd1, row)) col_moved = col - 2'd1;
    end else if (right_rise && !left_rise && col != COL_RIGHT) begin
      if (!move_blocked(heights, col + 2'd1, row)) col_moved = col + 2'd1;
    end
  end

  // Heights after this cycle's landing events; a completed line takes
  // priority and pulls the two other stacks down by one.
  always_comb begin
    heights_land = heights;
    land_full    = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (aligne) begin
        if (2'(i) != col) heights_land[i] = height_dec(heights[i]);
      end else if (plus_vec[i]) begin
        heights_land[i] = height_inc(heights[i]);
      end
      if (heights_land[i] == MAX_HEIGHT) land_full = 1'b1;
    end
  end

  // Game sequencing, stack/score bookkeeping and button edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      col     <= COL_CENTRE;
      heights <= '0;
      score   <= '0;
      start_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      start_q <= start;
      left_q  <= btn_left;
      right_q <= btn_right;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state   <= ST_FALL;
            heights <= '0;
            score   <= '0;
            col     <= COL_CENTRE;
          end
        end
        ST_FALL: begin
          col <= col_moved;
          if (pulse) state <= ST_LAND;
        end
        ST_LAND: begin
          heights <= heights_land;
          if (aligne) score <= score_inc;
          col   <= landing ? COL_CENTRE : col_moved;
          state <= (perdu || land_full) ? ST_OVER : ST_FALL;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hauteur_gauche = heights[0];
  assign hauteur_centre = heights[1];
  assign hauteur_droite = heights[2];
  assign playing        = (state == ST_FALL) || (state == ST_LAND);
  assign game_over      = (state == ST_OVER);

endmodule

// File: tb/tb_brick_game_sequencer.sv
// Randomised scoreboard bench for brick_game_sequencer against a rule-level
// reference model of the game.
module tb_brick_game_sequencer;

  localparam int unsigned TICK = 8;
  localparam int unsigned FAST = 2;
  localparam int unsigned SW   = 2;
  localparam int          MAXH = 5;
  localparam int          SMAX = (1 << SW) - 1;
  localparam int          NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset, start, btn_left, btn_right, btn_drop;
  logic          plus_gauche, plus_centre, plus_droite, aligne, perdu;
  logic [2:0]    row;
  logic          pulse, playing, game_over;
  logic [1:0]    col;
  logic [2:0]    hauteur_gauche, hauteur_centre, hauteur_droite;
  logic [SW-1:0] score;

  brick_game_sequencer #(
    .TICK_CYCLES (TICK),
    .FAST_CYCLES (FAST),
    .SCORE_W     (SW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_drop       (btn_drop),
    .plus_gauche    (plus_gauche),
    .plus_centre    (plus_centre),
    .plus_droite    (plus_droite),
    .aligne         (aligne),
    .perdu          (perdu),
    .row            (row),
    .pulse          (pulse),
    .col            (col),
    .hauteur_gauche (hauteur_gauche),
    .hauteur_centre (hauteur_centre),
    .hauteur_droite (hauteur_droite),
    .score          (score),
    .playing        (playing),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_FALL, M_LAND, M_OVER} mode_t;
  typedef struct {
    int p;
    int c;
    int h0;
    int h1;
    int h2;
    int s;
    int play;
    int over;
  } exp_t;

  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: describes the cycle that follows the next clock edge.
  mode_t m_mode;
  int    m_h[3];
  int    m_score, m_col, m_n, m_pulse;
  int    m_sp, m_lp, m_rp;

  task automatic model_reset();
    m_mode = M_IDLE; m_col = 1; m_score = 0; m_n = 0; m_pulse = 0;
    m_sp = 0; m_lp = 0; m_rp = 0;
    for (int i = 0; i < 3; i++) m_h[i] = 0;
  endtask

  // Apply the game rules to the inputs currently driven.
  task automatic model_step();
    int srise, lrise, rrise, moved, tgt, landing, full;
    if (reset) begin
      model_reset();
      return;
    end
    srise = start && !m_sp;
    lrise = btn_left && !m_lp;
    rrise = btn_right && !m_rp;
    moved = m_col;
    tgt   = -1;
    if (lrise && !rrise && m_col > 0) tgt = m_col - 1;
    if (rrise && !lrise && m_col < 2) tgt = m_col + 1;
    if (tgt >= 0 && m_h[tgt] + int'(row) <= MAXH) moved = tgt;
    case (m_mode)
      M_IDLE, M_OVER: begin
        if (srise) begin
          m_mode = M_FALL; m_col = 1; m_score = 0; m_n = 0; m_pulse = 0;
          for (int i = 0; i < 3; i++) m_h[i] = 0;
        end
      end
      M_FALL: begin
        m_col = moved;
        if (m_pulse != 0) begin
          m_mode = M_LAND; m_pulse = 0; m_n = 0;
        end else begin
          // pulse lands in the first fall cycle whose index has reached the
          // period selected by btn_drop during the cycle before it, minus one
          m_n = m_n + 1;
          m_pulse = (m_n >= (btn_drop ? FAST : TICK) - 1) ? 1 : 0;
        end
      end
      M_LAND: begin
        landing = aligne || plus_gauche || plus_centre || plus_droite;
        if (aligne) begin
          for (int i = 0; i < 3; i++)
            if (i != m_col && m_h[i] > 0) m_h[i] = m_h[i] - 1;
          if (m_score < SMAX) m_score = m_score + 1;
        end else begin
          if (plus_gauche && m_h[0] < MAXH) m_h[0] = m_h[0] + 1;
          if (plus_centre && m_h[1] < MAXH) m_h[1] = m_h[1] + 1;
          if (plus_droite && m_h[2] < MAXH) m_h[2] = m_h[2] + 1;
        end
        full = 0;
        for (int i = 0; i < 3; i++) if (m_h[i] == MAXH) full = 1;
        m_col  = landing ? 1 : moved;
        m_mode = (perdu || full) ? M_OVER : M_FALL;
        m_n = 0; m_pulse = 0;
      end
      default: ;
    endcase
    m_sp = start; m_lp = btn_left; m_rp = btn_right;
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.p = m_pulse; e.c = m_col; e.h0 = m_h[0]; e.h1 = m_h[1]; e.h2 = m_h[2];
    e.s = m_score;
    e.play = (m_mode == M_FALL || m_mode == M_LAND) ? 1 : 0;
    e.over = (m_mode == M_OVER) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compare each presented output cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pulse", int'(pulse), e.p);
        chk("col", int'(col), e.c);
        chk("hauteur_gauche", int'(hauteur_gauche), e.h0);
        chk("hauteur_centre", int'(hauteur_centre), e.h1);
        chk("hauteur_droite", int'(hauteur_droite), e.h2);
        chk("score", int'(score), e.s);
        chk("playing", int'(playing), e.play);
        chk("game_over", int'(game_over), e.over);
      end
    end
  end

  task automatic new_landing_events();
    int r;
    r = int'($urandom_range(0, 15));
    aligne = 1'b0; perdu = 1'b0;
    plus_gauche = 1'b0; plus_centre = 1'b0; plus_droite = 1'b0;
    if (r == 0) perdu = 1'b1;
    if (r >= 1 && r <= 3) begin
      aligne = 1'b1;
      plus_centre = 1'($urandom_range(0, 1));
    end else if (r >= 4 && r <= 12) begin
      case ($urandom_range(0, 2))
        0: plus_gauche = 1'b1;
        1: plus_centre = 1'b1;
        default: plus_droite = 1'b1;
      endcase
    end
  endtask

  // Stimulus: random play, gravity events held from LAND until the next pulse.
  initial begin
    int rst_left;
    reset = 1'b1; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    plus_gauche = 1'b0; plus_centre = 1'b0; plus_droite = 1'b0;
    aligne = 1'b0; perdu = 1'b0; row = 3'd0;
    model_reset();
    rst_left = 3;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 699) == 0) rst_left = 2;
      end
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if ($urandom_range(0, 3) == 0) start = ~start;
      end else if ($urandom_range(0, 7) == 0) begin
        start = ~start;
      end
      if ($urandom_range(0, 2) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 2) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 9) == 0) btn_drop = ~btn_drop;
      row = 3'($urandom_range(0, 5));
      if (m_mode == M_LAND) new_landing_events();
      else if (m_pulse != 0) begin
        aligne = 1'b0; perdu = 1'b0;
        plus_gauche = 1'b0; plus_centre = 1'b0; plus_droite = 1'b0;
      end
      model_step();
      @(posedge clk);
      exp_q.push_back(snapshot());
      #1;
    end
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
